// File: rtl/histo_pkg.sv
// Shared constants and receiver state type for the serial histogram link.
// Used by the histogram, its serializer and histo_serial_rx.
package histo_pkg;

    localparam int unsigned HISTO_DATA_W   = 24;
    localparam int unsigned HISTO_BIN_W    = 10;
    localparam int unsigned HISTO_NUM_BINS = 1024;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_e;

endpackage

// File: rtl/histo_rx_bit_timer.sv
// Bit-period counter for histo_serial_rx.
// Gives a mid-bit strobe and a full-bit strobe; clearing restarts the period.
module histo_rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic mid_tick_c,
    output logic full_tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign mid_tick_c  = (cnt_q == CNT_W'(CLKS_PER_BIT/2 - 1));
    assign full_tick_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i || full_tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/histo_serial_rx.sv
// Serial histogram receiver: rebuilds bin/count words from the start/stop framed stream.
// Optional HISTO_SERIAL_RX_SUM_EN adds sum_o, the per-frame total of received counts.
module histo_serial_rx
    import histo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned DATA_W       = HISTO_DATA_W,
    parameter int unsigned BIN_W        = HISTO_BIN_W,
    parameter int unsigned NUM_BINS     = HISTO_NUM_BINS,
    parameter int unsigned GAP_CLKS     = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              serial_i,
    output logic [DATA_W-1:0] word_o,
    output logic [BIN_W-1:0]  bin_o,
    output logic              word_vld_o,
    output logic              frame_done_o,
    output logic              stop_err_o,
    output logic              sync_lost_o,
`ifdef HISTO_SERIAL_RX_SUM_EN
    output logic [DATA_W+BIN_W-1:0] sum_o,
`endif
    output logic              busy_o
);

    localparam int unsigned BC_W  = $clog2(DATA_W + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CLKS + 1);

    rx_state_e         state_q, state_nxt;
    logic [1:0]        sync_q;
    logic              rx_bit;
    logic [BIN_W-1:0]  bin_q, bin_nxt;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [GAP_W-1:0]  gap_q, gap_nxt;
    logic              word_vld_nxt, frame_done_nxt, stop_err_nxt, sync_lost_nxt;
    logic              timer_clr_c, mid_tick_c, full_tick_c;
    logic              last_bin_c;

    assign rx_bit     = sync_q[1];
    assign last_bin_c = (bin_q == BIN_W'(NUM_BINS - 1));

    histo_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (timer_clr_c),
        .mid_tick_c  (mid_tick_c),
        .full_tick_c (full_tick_c)
    );

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_nxt      = state_q;
        bin_nxt        = bin_q;
        bit_cnt_nxt    = bit_cnt_q;
        shift_nxt      = shift_q;
        gap_nxt        = '0;
        word_vld_nxt   = 1'b0;
        frame_done_nxt = 1'b0;
        stop_err_nxt   = 1'b0;
        sync_lost_nxt  = 1'b0;
        timer_clr_c    = 1'b0;

        case (state_q)
            IDLE: begin
                timer_clr_c = 1'b1;
                bit_cnt_nxt = '0;
                if (!rx_bit) begin
                    state_nxt = START;
                end else if (gap_q != GAP_W'(GAP_CLKS)) begin
                    gap_nxt = gap_q + GAP_W'(1);
                    if (gap_q == GAP_W'(GAP_CLKS - 1) && bin_q != '0) begin
                        sync_lost_nxt = 1'b1;
                        bin_nxt       = '0;
                    end
                end else begin
                    gap_nxt = gap_q;
                end
            end
            START: begin
                if (mid_tick_c) begin
                    // Re-anchor the bit timer to mid-start so data samples land mid-bit.
                    timer_clr_c = 1'b1;
                    state_nxt   = rx_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick_c) begin
                    shift_nxt   = {rx_bit, shift_q[DATA_W-1:1]};
                    bit_cnt_nxt = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (full_tick_c) begin
                    if (rx_bit) begin
                        word_vld_nxt   = 1'b1;
                        frame_done_nxt = last_bin_c;
                        bin_nxt        = last_bin_c ? '0 : bin_q + BIN_W'(1);
                        state_nxt      = IDLE;
                    end else begin
                        stop_err_nxt = 1'b1;
                        state_nxt    = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (rx_bit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            bin_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            gap_q        <= '0;
            word_o       <= '0;
            bin_o        <= '0;
            word_vld_o   <= 1'b0;
            frame_done_o <= 1'b0;
            stop_err_o   <= 1'b0;
            sync_lost_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], serial_i};
            state_q      <= state_nxt;
            bin_q        <= bin_nxt;
            bit_cnt_q    <= bit_cnt_nxt;
            shift_q      <= shift_nxt;
            gap_q        <= gap_nxt;
            word_vld_o   <= word_vld_nxt;
            frame_done_o <= frame_done_nxt;
            stop_err_o   <= stop_err_nxt;
            sync_lost_o  <= sync_lost_nxt;
            busy_o       <= (state_nxt != IDLE);
            if (word_vld_nxt) begin
                word_o <= shift_q;
                bin_o  <= bin_q;
            end
        end
    end

`ifdef HISTO_SERIAL_RX_SUM_EN
    localparam int unsigned SUM_W = DATA_W + BIN_W;

    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] acc_add_c;

    // Bin 0 starts a fresh frame total.
    assign acc_add_c = ((bin_q == '0) ? '0 : acc_q) + SUM_W'(shift_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            sum_o <= '0;
        end else if (sync_lost_nxt) begin
            acc_q <= '0;
        end else if (word_vld_nxt) begin
            acc_q <= acc_add_c;
            if (frame_done_nxt) begin
                sum_o <= acc_add_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_histo_serial_rx.sv
// Randomized bench for histo_serial_rx against a queue-based event model.
// Define HISTO_SERIAL_RX_SUM_EN to also check sum_o.
module tb_histo_serial_rx;

    localparam int CPB = 8;
    localparam int DW  = 24;
    localparam int BW  = 10;
    localparam int NB  = 32;
    localparam int GAP = 4096;
    localparam int SW  = DW + BW;
    // Strobe edge after the start edge: 2 sync + (DW+1.5) bit periods + 1 register stage.
    localparam int LAT = 2 + ((2*DW + 3) * CPB) / 2 + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          serial_i = 1'b1;
    logic [DW-1:0] word_o;
    logic [BW-1:0] bin_o;
    logic          word_vld_o, frame_done_o, stop_err_o, sync_lost_o, busy_o;
`ifdef HISTO_SERIAL_RX_SUM_EN
    logic [SW-1:0] sum_o;
`endif

    histo_serial_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW),
        .BIN_W        (BW),
        .NUM_BINS     (NB),
        .GAP_CLKS     (GAP)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .serial_i     (serial_i),
        .word_o       (word_o),
        .bin_o        (bin_o),
        .word_vld_o   (word_vld_o),
        .frame_done_o (frame_done_o),
        .stop_err_o   (stop_err_o),
        .sync_lost_o  (sync_lost_o),
`ifdef HISTO_SERIAL_RX_SUM_EN
        .sum_o        (sum_o),
`endif
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // flags = {word_vld, frame_done, stop_err, sync_lost}
    typedef struct {
        logic [3:0]    flags;
        logic [DW-1:0] word;
        logic [BW-1:0] bin;
        int            exp_cyc;
        logic [SW-1:0] sum;
    } ev_t;

    ev_t           exp_q[$];
    ev_t           mon_ev;
    int            model_bin = 0;
    logic [SW-1:0] model_sum = '0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] last_word;
    int            c0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle_bits(input int n);
        serial_i = 1'b1;
        repeat (n * CPB) @(negedge clk_i);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic stop_bit);
        ev_t e;
        @(negedge clk_i);
        e.exp_cyc = cyc + LAT;
        e.word    = w;
        e.bin     = BW'(model_bin);
        if (stop_bit) begin
            e.flags   = {1'b1, (model_bin == NB - 1), 2'b00};
            model_sum = ((model_bin == 0) ? '0 : model_sum) + SW'(w);
            e.sum     = model_sum;
            model_bin = (model_bin + 1) % NB;
            last_word = w;
        end else begin
            e.flags = 4'b0010;
            e.sum   = '0;
        end
        exp_q.push_back(e);
        serial_i = 1'b0;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < DW; i++) begin
            serial_i = w[i];
            repeat (CPB) @(negedge clk_i);
        end
        serial_i = stop_bit;
        repeat (CPB) @(negedge clk_i);
        serial_i = 1'b1;
    endtask

    // Any strobe must match the next predicted event.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && (word_vld_o || frame_done_o || stop_err_o || sync_lost_o)) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_strobe",
                             {60'd0, word_vld_o, frame_done_o, stop_err_o, sync_lost_o}, 64'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check_eq("strobe_kind",
                             {60'd0, word_vld_o, frame_done_o, stop_err_o, sync_lost_o},
                             {60'd0, mon_ev.flags});
                    if (mon_ev.flags[3]) begin
                        check_eq("word", word_o, mon_ev.word);
                        check_eq("bin", bin_o, mon_ev.bin);
                    end
                    if (mon_ev.exp_cyc >= 0) check_eq("latency", cyc, mon_ev.exp_cyc);
`ifdef HISTO_SERIAL_RX_SUM_EN
                    if (mon_ev.flags[2]) check_eq("sum", sum_o, mon_ev.sum);
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete, %0d events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t lost;
        int  bin_before;

        repeat (3) @(negedge clk_i);
        check_eq("rst_word", word_o, 0);
        check_eq("rst_bin", bin_o, 0);
        check_eq("rst_strobes", {word_vld_o, frame_done_o, stop_err_o, sync_lost_o}, 0);
        check_eq("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        // Single known word.
        send_word(24'hA5C30F, 1'b1);
        idle_bits(2);
        check_eq("t1_pending", exp_q.size(), 0);
        check_eq("t1_word_hold", word_o, 24'hA5C30F);
        check_eq("t1_bin_hold", bin_o, 0);

        // Finish this frame, then a full frame with value = bin index, then one more.
        while (model_bin != 0) send_word(DW'(model_bin), 1'b1);
        for (int i = 0; i < NB; i++) send_word(DW'(i), 1'b1);
        send_word(DW'($urandom()), 1'b1);
        idle_bits(1);
        check_eq("t2_pending", exp_q.size(), 0);

        // Stop-bit error keeps the index and the last word.
        bin_before = model_bin;
        send_word(DW'($urandom()), 1'b0);
        idle_bits(2);
        check_eq("t3_word_hold", word_o, last_word);
        check_eq("t3_model_bin", model_bin, bin_before);
        send_word(DW'($urandom()), 1'b1);
        idle_bits(1);
        check_eq("t3_pending", exp_q.size(), 0);

        // Partial frame then long gap -> one sync_lost; then idle at index 0 -> nothing.
        for (int i = 0; i < 10; i++) begin
            send_word(DW'($urandom()), 1'b1);
            idle_bits(int'($urandom_range(0, 2)));
        end
        if (model_bin != 0) begin
            lost.flags   = 4'b0001;
            lost.word    = '0;
            lost.bin     = '0;
            lost.exp_cyc = -1;
            lost.sum     = '0;
            exp_q.push_back(lost);
        end
        model_bin = 0;
        model_sum = '0;
        repeat (GAP + 100) @(negedge clk_i);
        check_eq("t4_lost_seen", exp_q.size(), 0);
        repeat (5000) @(negedge clk_i);
        check_eq("t4_idle_busy", busy_o, 0);
        send_word(DW'($urandom()), 1'b1);
        idle_bits(1);
        check_eq("t4_pending", exp_q.size(), 0);

        // Two-clock low glitch on an idle line.
        @(negedge clk_i);
        c0 = cyc;
        serial_i = 1'b0;
        repeat (2) @(negedge clk_i);
        serial_i = 1'b1;
        while (cyc < c0 + 4) @(negedge clk_i);
        check_eq("t5_glitch_busy", busy_o, 1);
        while (cyc < c0 + CPB/2 + 3) @(negedge clk_i);
        check_eq("t5_glitch_idle", busy_o, 0);
        repeat (20) @(negedge clk_i);
        check_eq("t5_pending", exp_q.size(), 0);

        // Reset in the middle of the data bits.
        serial_i = 1'b0;
        repeat (CPB * 6) @(negedge clk_i);
        check_eq("t6_busy_pre", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check_eq("t6_rst_word", word_o, 0);
        check_eq("t6_rst_bin", bin_o, 0);
        check_eq("t6_rst_busy", busy_o, 0);
        check_eq("t6_rst_strobes", {word_vld_o, frame_done_o, stop_err_o, sync_lost_o}, 0);
        serial_i  = 1'b1;
        model_bin = 0;
        model_sum = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
`ifdef HISTO_SERIAL_RX_SUM_EN
        for (int i = 0; i < NB; i++) send_word(DW'(1), 1'b1);
        idle_bits(1);
        check_eq("t6_sum_ones", sum_o, NB);
`else
        for (int i = 0; i < NB; i++) send_word(DW'($urandom()), 1'b1);
`endif
        send_word(DW'($urandom()), 1'b1);
        idle_bits(2);
        check_eq("t6_bin_after_wrap", bin_o, 0);
        check_eq("final_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
